// File: rtl/kolibri_pkg.sv
// Shared definitions for the SD-card SPI master: register offsets, status bit
// positions, FSM state encoding and the power-on clock divider value.
package kolibri_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IEN  = 2;
  localparam int STAT_OVR  = 3;
  localparam int STAT_SEL0 = 4;
  localparam int STAT_SEL1 = 5;

  localparam int CTRL_SEL0 = 0;
  localparam int CTRL_SEL1 = 1;
  localparam int CTRL_IEN  = 2;
  localparam int CTRL_CLR  = 7;

  // 48 MHz / (2 * (59 + 1)) = 400 kHz, the SD identification-mode clock
  localparam logic [7:0] SPI_DIV_INIT = 8'd59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } spi_state_e;

  function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                             input logic ien, input logic ovr,
                                             input logic sel0, input logic sel1);
    logic [7:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_DONE] = done;
    s[STAT_IEN]  = ien;
    s[STAT_OVR]  = ovr;
    s[STAT_SEL0] = sel0;
    s[STAT_SEL1] = sel1;
    return s;
  endfunction

endpackage

// File: rtl/spi_half_div.sv
// Half-period timer for the SPI clock: 8-bit down-counter that reloads on
// demand and flags terminal count while it sits at zero.
module spi_half_div (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tc_o
);

  logic [7:0] cnt_q, cnt_d;

  // Parks at zero when no reload arrives, so terminal count stays asserted
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/sd_spi_ctrl.sv
// Byte-wide SPI master (mode 0, MSB first) for the two SD slots, with CPU
// register file for data, control/status and the SCLK divider.
module sd_spi_ctrl
  import kolibri_pkg::*;
#(
  parameter logic [7:0] DIV_RST = SPI_DIV_INIT
) (
  input  logic       MHZ48,
  input  logic       RES,
  input  logic       STB,
  input  logic [1:0] A,
  input  logic       RW,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       nSD0,
  output logic       nSD1,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       IRQ
);

  spi_state_e state_q, state_d;

  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] div_q, div_d;
  logic [7:0] div_act_q, div_act_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       sel0_q, sel0_d;
  logic       sel1_q, sel1_d;
  logic       ien_q, ien_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       irq_q, irq_d;

  logic       busy;
  logic       wr;
  logic       data_wr;
  logic       ctrl_wr;
  logic       div_wr;
  logic       cnt_load;
  logic [7:0] cnt_val;
  logic       cnt_tc;

  assign busy    = (state_q != ST_IDLE);
  assign wr      = STB & ~RW;
  assign data_wr = wr && (A == REG_DATA);
  assign ctrl_wr = wr && (A == REG_CTRL);
  assign div_wr  = wr && (A == REG_DIV);

  // The first half-period uses the divider being latched on the start edge
  assign cnt_val = (state_q == ST_IDLE) ? div_q : div_act_q;

  spi_half_div u_half_div (
    .clk_i      (MHZ48),
    .rst_i      (RES),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    div_d     = div_q;
    div_act_d = div_act_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    sel0_d    = sel0_q;
    sel1_d    = sel1_q;
    ien_d     = ien_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    irq_d     = done_q & ien_q;
    cnt_load  = 1'b0;

    if (ctrl_wr) begin
      sel0_d = WDATA[CTRL_SEL0];
      sel1_d = WDATA[CTRL_SEL1];
      ien_d  = WDATA[CTRL_IEN];
      if (WDATA[CTRL_CLR]) begin
        done_d = 1'b0;
        ovr_d  = 1'b0;
      end
    end

    if (div_wr) begin
      div_d = WDATA;
    end

    if (data_wr && busy) begin
      ovr_d = 1'b1;
    end

    // Transfer sequencing sits after the CTRL clear so a DONE set wins a tie
    unique case (state_q)
      ST_IDLE: begin
        if (data_wr) begin
          state_d   = ST_LOW;
          tx_d      = WDATA;
          div_act_d = div_q;
          bit_cnt_d = 3'd7;
          sclk_d    = 1'b0;
          mosi_d    = WDATA[7];
          done_d    = 1'b0;
          cnt_load  = 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_tc) begin
          state_d  = ST_HIGH;
          sclk_d   = 1'b1;
          rx_sh_d  = {rx_sh_q[6:0], MISO};
          cnt_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_tc) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != 3'd0) begin
            state_d   = ST_LOW;
            tx_d      = {tx_q[6:0], 1'b0};
            mosi_d    = tx_q[6];
            bit_cnt_d = bit_cnt_q - 3'd1;
            cnt_load  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            mosi_d  = 1'b1;
            rx_d    = rx_sh_q;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge MHZ48) begin
    if (RES) begin
      state_q   <= ST_IDLE;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_q      <= 8'h00;
      div_q     <= DIV_RST;
      div_act_q <= DIV_RST;
      bit_cnt_q <= 3'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      sel0_q    <= 1'b0;
      sel1_q    <= 1'b0;
      ien_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      div_act_q <= div_act_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      sel0_q    <= sel0_d;
      sel1_q    <= sel1_d;
      ien_q     <= ien_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    RDATA = 8'h00;
    unique case (A)
      REG_DATA: RDATA = rx_q;
      REG_CTRL: RDATA = status_byte(busy, done_q, ien_q, ovr_q, sel0_q, sel1_q);
      REG_DIV:  RDATA = div_q;
      default:  RDATA = 8'h00;
    endcase
  end

  assign nSD0 = ~sel0_q;
  assign nSD1 = ~sel1_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign IRQ  = irq_q;

endmodule
